// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam logic UART_IDLE      = 1'b1;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle o_bit_tick at the end of every bit period.
// UART_TX_FAST_SIM_EN forces the bit period to a single clock.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_en,
  output logic o_bit_tick
);

`ifdef UART_TX_FAST_SIM_EN
  localparam int EFF_CPB = 1;
`else
  localparam int EFF_CPB = CLKS_PER_BIT;
`endif

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(EFF_CPB - 1);

  logic [CNT_W-1:0] r_cnt;

  // Tick is taken from the live count so the FSM advances on the edge that
  // closes the period, keeping each bit exactly EFF_CPB cycles wide.
  assign o_bit_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_restart || !i_en || o_bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, data LSB first, stop bit.
// Build option UART_TX_FAST_SIM_EN shortens every bit to one clock.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_write,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_busy,
  output logic                 o_uart_tx
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_tx;
  logic                 r_busy;
  logic                 w_accept;
  logic                 w_tick;

  assign w_accept  = (r_state == IDLE) && i_write;
  assign o_busy    = r_busy;
  assign o_uart_tx = r_tx;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_restart  (w_accept),
    .i_en       (r_busy),
    .o_bit_tick (w_tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= UART_IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_write) begin
            r_shift <= i_data;
            r_state <= START;
            r_tx    <= UART_START_BIT;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_idx == LAST_IDX) begin
              r_state <= STOP;
              r_tx    <= UART_STOP_BIT;
            end else begin
              // Next bit is shift[1]; the line is already driving shift[0].
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + IDX_W'(1);
              r_tx    <= r_shift[1];
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_tx    <= UART_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= UART_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (4, 1 and 868 clocks per bit) checked
// against an ideal frame waveform built from the byte value.
module tb_uart_tx;

`ifdef UART_TX_FAST_SIM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w  [3];
  logic [7:0] d  [3];
  logic       busy [3];
  logic       tx   [3];
  int         per  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4)) u_d4 (
    .i_clk(clk), .i_rst(rst), .i_write(w[0]), .i_data(d[0]),
    .o_busy(busy[0]), .o_uart_tx(tx[0]));
  uart_tx #(.CLKS_PER_BIT(1)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_write(w[1]), .i_data(d[1]),
    .o_busy(busy[1]), .o_uart_tx(tx[1]));
  uart_tx #(.CLKS_PER_BIT(868)) u_d868 (
    .i_clk(clk), .i_rst(rst), .i_write(w[2]), .i_data(d[2]),
    .o_busy(busy[2]), .o_uart_tx(tx[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send byte b on instance s and compare every cycle of the frame with the
  // ideal 10-bit waveform; optionally pulse a competing write at cycle pk.
  task automatic frame(input int s, input logic [7:0] b, input int pk);
    int p;
    logic [9:0] f;
    p = per[s];
    f = {1'b1, b, 1'b0};
    w[s] = 1'b1;
    d[s] = b;
    tick();
    w[s] = 1'b0;
    d[s] = 8'($urandom);
    for (int k = 0; k < 10 * p; k++) begin
      chk($sformatf("line s%0d b%02h k%0d", s, b, k), 32'(tx[s]), 32'(f[k / p]));
      chk($sformatf("busy s%0d b%02h k%0d", s, b, k), 32'(busy[s]), 32'd1);
      if (k == pk) begin
        w[s] = 1'b1;
        d[s] = 8'hFF;
      end else begin
        w[s] = 1'b0;
      end
      tick();
    end
    w[s] = 1'b0;
    chk($sformatf("end busy s%0d", s), 32'(busy[s]), 32'd0);
    chk($sformatf("end line s%0d", s), 32'(tx[s]), 32'd1);
  endtask

  task automatic idle_check(input int s, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s busy k%0d", tag, k), 32'(busy[s]), 32'd0);
      chk($sformatf("%s line k%0d", tag, k), 32'(tx[s]), 32'd1);
      tick();
    end
  endtask

  initial begin
    logic [7:0] bytes [3];
    logic       cap   [$];
    int         idx;
    logic       prev_busy;

    per[0] = FAST ? 1 : 4;
    per[1] = 1;
    per[2] = FAST ? 1 : 868;
    for (int i = 0; i < 3; i++) begin
      w[i] = 1'b0;
      d[i] = 8'h00;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst busy s%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst line s%0d", i), 32'(tx[i]), 32'd1);
    end
    rst = 1'b0;
    tick();
    idle_check(0, 3, "post-rst");

    // Alternating pattern, LSB-first corner bytes, random bytes
    frame(0, 8'h55, -1);
    frame(0, 8'h01, -1);
    frame(0, 8'h80, -1);
    for (int i = 0; i < 3; i++) frame(0, 8'($urandom), -1);
    for (int i = 0; i < 3; i++) frame(1, 8'($urandom), -1);

    // Write during a frame is ignored, and no second frame follows
    frame(0, 8'hA5, 5 * per[0]);
    idle_check(0, 12, "after-ignore");

    // Continuous stream: producer write = !busy, advances on each acceptance
    bytes[0] = 8'h41;
    bytes[1] = 8'h42;
    bytes[2] = 8'h43;
    idx = 0;
    prev_busy = 1'b0;
    w[1] = 1'b1;
    d[1] = bytes[0];
    for (int k = 0; k < 40; k++) begin
      int fi;
      int pos;
      logic [9:0] f;
      tick();
      fi  = k / 11;
      pos = k % 11;
      if (fi < 3) begin
        f = {1'b1, bytes[fi], 1'b0};
        chk($sformatf("stream line k%0d", k), 32'(tx[1]), pos < 10 ? 32'(f[pos]) : 32'd1);
        chk($sformatf("stream busy k%0d", k), 32'(busy[1]), pos < 10 ? 32'd1 : 32'd0);
      end else begin
        chk($sformatf("stream tail line k%0d", k), 32'(tx[1]), 32'd1);
        chk($sformatf("stream tail busy k%0d", k), 32'(busy[1]), 32'd0);
      end
      cap.push_back(tx[1]);
      if (busy[1] && !prev_busy) idx++;
      prev_busy = busy[1];
      w[1] = !busy[1] && (idx < 3);
      d[1] = (idx < 3) ? bytes[idx] : 8'h00;
    end
    w[1] = 1'b0;
    // Decode the captured line like a receiver would
    begin
      int n = 0;
      int j = 0;
      while (j < cap.size() && n < 3) begin
        if (cap[j] == 1'b0 && j + 9 < cap.size()) begin
          logic [7:0] v;
          for (int b = 0; b < 8; b++) v[b] = cap[j + 1 + b];
          chk($sformatf("decode byte%0d", n), 32'(v), 32'(bytes[n]));
          chk($sformatf("decode stop%0d", n), 32'(cap[j + 9]), 32'd1);
          n++;
          j += 10;
        end else begin
          j++;
        end
      end
      chk("decode count", 32'(n), 32'd3);
    end

    // Async reset mid-DATA: outputs return to idle before the next edge
    w[0] = 1'b1;
    d[0] = 8'h00;
    tick();
    w[0] = 1'b0;
    repeat (3 * per[0] + 1) tick();
    chk("pre-rst busy", 32'(busy[0]), 32'd1);
    chk("pre-rst line", 32'(tx[0]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst busy", 32'(busy[0]), 32'd0);
    chk("async rst line", 32'(tx[0]), 32'd1);
    tick();
    rst = 1'b0;
    idle_check(0, 20, "rst-quiet");
    frame(0, 8'hC3, -1);

    // Long bit period (or one clock under the fast-sim build)
    frame(2, 8'h3C, -1);
    idle_check(2, 2, "d868-idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 asynchronous serial transmitter: accepts one byte per handshake and shifts it out on a single line.
- Frame: start bit (0), 8 data bits LSB first, stop bit (1).
- Sits between a byte producer (e.g. input_data, which advances on i_get_next) and the board TX pin.
- The producer's get-next strobe is driven by the inverse of o_busy.

Parameters:
- CLKS_PER_BIT, 868, i_clk cycles per serial bit (100 MHz / 115200 baud); legal range 1..65535.
- DATA_BITS, 8, payload bits per frame; fixed at 8 in this release.

Ports:
- i_clk  input  1  system clock; all state on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_write  input  1  request to send i_data; sampled on the rising edge.
- i_data  input  8  byte to transmit; captured only on an accepted write.
- o_busy  output  1  high while a frame is in progress; writes are ignored while high.
- o_uart_tx  output  1  serial line, registered; idles high.

Behaviour:
- Reset (async, any time including mid-frame): state IDLE, o_uart_tx=1, o_busy=0, shift register and counters cleared. The frame is abandoned with no partial stop bit.
- States: IDLE, START, DATA, STOP.
- IDLE: o_uart_tx=1, o_busy=0.
  - Rising edge with i_write=1: latch i_data into the shift register, enter START, o_uart_tx=0, o_busy=1.
  - Both outputs change on that same edge (zero-cycle latency from the accepting edge).
- START: hold 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: drive shift_reg[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After bit 7, enter STOP.
- STOP: drive 1 for CLKS_PER_BIT cycles, then IDLE with o_busy=0 on the edge that ends the stop bit.
- Frame duration: exactly 10*CLKS_PER_BIT cycles with o_busy=1.
- Back-to-back operation:
  - i_write is not sampled on the edge that leaves STOP.
  - Earliest next acceptance is the following edge.
  - Consequences: minimum inter-frame gap of 1 idle-high cycle; frame period 10*CLKS_PER_BIT+1 when i_write is tied to !o_busy.
- i_write while o_busy=1 is ignored; i_data changes during a frame have no effect.
- Bit-period counter: width $clog2(CLKS_PER_BIT+1), counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- CLKS_PER_BIT=1 is legal: one bit per clock, 10-cycle frames.
- o_uart_tx comes straight from a flop (glitch-free); o_busy is registered.

Optional Feature:
- Macro: UART_TX_FAST_SIM_EN.
- Defined: the effective bit period is forced to 1 clock regardless of CLKS_PER_BIT, so full frames fit in short simulations (four back-to-back frames in 44 cycles).
- Undefined: the bit period equals CLKS_PER_BIT.
- No other behaviour differs.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP);
  - UART_START_BIT=1'b0, UART_STOP_BIT=1'b1, UART_IDLE=1'b1;
  - DATA_BITS default.
- One natural sub-module, uart_baud_tick:
  - counts clocks and emits a 1-cycle bit_tick every effective CLKS_PER_BIT;
  - restarts on frame start;
  - honours UART_TX_FAST_SIM_EN.
- The top FSM consumes bit_tick.

Test Plan:
- Reset: assert i_rst asynchronously mid-DATA with CLKS_PER_BIT=4 -> o_uart_tx=1 and o_busy=0 immediately (before the next edge); no further transitions until a write.
- Single frame: CLKS_PER_BIT=4, write 0x55 -> line sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; o_busy high exactly 40 cycles, then 0.
- LSB-first check: write 0x01 -> start 0, then 1, then seven 0s, then stop 1; write 0x80 -> start 0, seven 0s, 1, stop 1.
- Ignore while busy: during a 0xA5 frame, pulse i_write with i_data=0xFF -> the frame still carries 0xA5; no second frame starts.
- Continuous stream: i_write=!o_busy, producer bytes 0x41,0x42,0x43, CLKS_PER_BIT=1 -> three frames, each 10 cycles busy plus 1 idle-high cycle; decoded bytes match in order.
- Fast-sim: UART_TX_FAST_SIM_EN defined with CLKS_PER_BIT=868 -> a 0x3C frame completes in 10 cycles; undefined -> 8680 cycles.
